multi_queue_issue: RTL
======================

Name: multi_queue_issue

Overview:
- Pop-side consumer for `multi_queue`, i.e. the reader end of the queue's push/pop window interface.
- Each cycle it inspects the queue's head window (`data_pop`/`pop_valid` in queue terms) and selects up to ISSUE_WIDTH leading entries. It drives the queue's `pop_num` and registers the selected entries into an output pipeline stage.
- The output stage feeds the downstream issue/decode logic under a stage-level ready/stall handshake. Entries tagged "serialize" are issued alone.

Parameters:
- DATA_WIDTH, 32, width of one queue entry.
- CHANNEL, 4, queue window width; must match the connected `multi_queue` CHANNEL.
- ISSUE_WIDTH, 2, maximum entries issued per cycle; 1 <= ISSUE_WIDTH <= CHANNEL.
- POP_W, $clog2(CHANNEL+1), width of the pop count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush; the queue is flushed in the same cycle
- q_data  in  CHANNEL x DATA_WIDTH  queue head window, slot 0 = oldest
- q_valid  in  CHANNEL  per-slot valid from the queue
- q_serial  in  CHANNEL  per-slot serialize flag, qualified by q_valid
- q_pop_num  out  POP_W  number of entries consumed this cycle; goes to the queue's pop_num
- out_data  out  ISSUE_WIDTH x DATA_WIDTH  registered issue slots
- out_valid  out  ISSUE_WIDTH  registered slot valids, always contiguous from slot 0
- out_ready  in  1  downstream accepts the current output group at the clock edge
- stall_cnt  out  16  saturating count of back-pressured cycles

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, stall_cnt=0.
  - q_pop_num=0 combinationally whenever rst=1.
- Leading count L:
  - L = number of consecutive set bits of q_valid starting at slot 0.
  - Bits above the first 0 are ignored, even if set.
- Selection n:
  - Start with n = min(L, ISSUE_WIDTH).
  - If q_serial[0] is set and q_valid[0] is set, n = min(n, 1).
  - Otherwise, for the smallest k in 1..n-1 with q_serial[k] set, n = k. The serialize entry waits to become slot 0 in a later cycle.
- Load condition: load = out_ready | ~out_valid[0], so an empty stage always refills.
- q_pop_num (combinational):
  - Equals n when load & ~flush & ~rst; otherwise 0.
  - It never exceeds L, so the block cannot pop past the queue's valid entries.
- Output register update, at posedge, in priority order:
  1. rst or flush: out_valid <= 0, out_data <= 0.
  2. load: slot i gets q_data[i] and out_valid[i] <= (i < n); slots i >= n get out_data = 0.
  3. Otherwise hold all output registers.
- Latency: an entry visible in the window at cycle t appears on out_* at cycle t+1 if popped at t.
- Throughput: ISSUE_WIDTH entries per cycle when out_ready=1 and no serialize entry is present.
- stall_cnt:
  - Increments by 1 at posedge when out_valid[0]=1 & out_ready=0 & ~flush; saturates at 16'hFFFF.
  - Cleared only by rst; flush does not clear it.
- Empty queue (q_valid=0) with load=1: n=0, q_pop_num=0, and out_valid goes to 0 next cycle (bubble).
- Stall with a full window: q_pop_num stays 0 and out_* is stable for every cycle out_ready=0.
- Flush concurrent with out_ready=1: the flush wins. Nothing is popped, and the downstream must ignore the group presented at the flush edge.
- Reset mid-stall: identical to a power-on reset; no entry is popped that cycle.

Test Plan:
All scenarios use DATA_WIDTH=8, CHANNEL=4, ISSUE_WIDTH=2.
- Reset check: rst high for 2 cycles with q_valid=4'b1111 -> q_pop_num=0 throughout; after release, out_valid=0 and stall_cnt=0.
- Streaming:
  - Stimulus: q_data={4,3,2,1}, q_valid=4'b1111, q_serial=0, out_ready=1.
  - Response: q_pop_num=2; next cycle out_data={2,1}, out_valid=2'b11.
  - Then the window shifts to {x,x,4,3} with q_valid=4'b0011 -> q_pop_num=2, then out_data={4,3}.
- Holes and partial windows:
  - q_valid=4'b1101 -> q_pop_num=1, next out_valid=2'b01, out_data slot0=1, slot1=0.
  - q_valid=0 -> q_pop_num=0, out_valid=0 next cycle.
- Serialize:
  - q_serial=4'b0010, q_valid=4'b1111 -> q_pop_num=1 (slot0 only).
  - Next window with the serialize entry at slot 0 -> q_pop_num=1, out_valid=2'b01.
  - q_serial=4'b0001 -> q_pop_num=1.
- Back-pressure:
  - out_valid=2'b11 with out_ready=0 held for 5 cycles -> q_pop_num=0, out_* stable, stall_cnt=5.
  - out_ready=1 -> group retires and the next 2 entries load.
  - Force stall_cnt to 16'hFFFE and stall 3 cycles -> saturates at 16'hFFFF.
- Flush: flush=1 with out_ready=1 and a full window -> q_pop_num=0 that cycle, out_valid=0 next cycle, stall_cnt unchanged.

Source files
------------

// File: rtl/multi_queue_issue.sv
// Pop-side issue stage for multi_queue: takes up to ISSUE_WIDTH leading window
// entries per cycle into a registered output group, issuing serialize entries alone.
module multi_queue_issue #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNEL     = 4,
  parameter int ISSUE_WIDTH = 2,
  parameter int POP_W       = $clog2(CHANNEL + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [CHANNEL-1:0][DATA_WIDTH-1:0]    q_data,
  input  logic [CHANNEL-1:0]                    q_valid,
  input  logic [CHANNEL-1:0]                    q_serial,
  output logic [POP_W-1:0]                      q_pop_num,
  output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] out_data,
  output logic [ISSUE_WIDTH-1:0]                out_valid,
  input  logic                                  out_ready,
  output logic [15:0]                           stall_cnt
);

  localparam logic [POP_W-1:0] IW_N = POP_W'(ISSUE_WIDTH);

  logic [POP_W-1:0] lead;
  logic [POP_W-1:0] sel;
  logic             run;
  logic             found;
  logic             load;

  assign load = out_ready | ~out_valid[0];

  always_comb begin
    lead  = '0;
    run   = 1'b1;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < CHANNEL; i++) begin
      if (run && q_valid[i]) lead = lead + POP_W'(1);
      else                   run  = 1'b0;
    end
    sel = (lead > IW_N) ? IW_N : lead;
    if (q_valid[0] && q_serial[0]) begin
      if (sel > POP_W'(1)) sel = POP_W'(1);
    end else begin
      // A younger serialize entry truncates the group so it later issues from slot 0.
      for (int k = 1; k < ISSUE_WIDTH; k++) begin
        if (!found && (POP_W'(k) < sel) && q_serial[k]) begin
          sel   = POP_W'(k);
          found = 1'b1;
        end
      end
    end
  end

  assign q_pop_num = (load && !flush && !rst) ? sel : '0;

  for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
    logic take;
    assign take = POP_W'(gi) < sel;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        out_valid[gi] <= 1'b0;
        out_data[gi]  <= '0;
      end else if (load) begin
        out_valid[gi] <= take;
        out_data[gi]  <= take ? q_data[gi] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid[0] && !out_ready && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
